vdiv_seq: RTL and testbench

- Requester side of the vector-divider handshake: drives the divider's input record (en, a, b) and consumes its output record (done, result).
- Accepts a packed vector of LANES operand pairs through a ready/valid port and issues one lane at a time to a single scalar divider.
- Collects the per-lane results, applies timeout recovery, and presents the finished result vector through a ready/valid port.
- Sits between the vector issue stage and the shared FP divider.

---
 rtl/vdiv_pkg.sv | 17 +
 rtl/vdiv_lane_buf.sv | 72 +++++++
 rtl/vdiv_seq.sv | 183 ++++++++++++++++++
 tb/tb_vdiv_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdiv_pkg.sv
// rtl/vdiv_pkg.sv - shared element type, state encoding and NaN constant for the vector divide sequencer
package vdiv_pkg;

    localparam int W = 16;

    typedef logic [W-1:0] elem_t;

    localparam elem_t CANON_NAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/vdiv_lane_buf.sv
// rtl/vdiv_lane_buf.sv - operand/result register file with lane-indexed read and write plus per-lane error flags
module vdiv_lane_buf #(
    parameter int EW    = 16,
    parameter int LANES = 4,
    parameter int LW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [LANES*EW-1:0] load_a,
    input  logic [LANES*EW-1:0] load_b,
    input  logic [LANES-1:0]   load_mask,
    input  logic [LW-1:0]      rd_lane,
    output logic [EW-1:0]      rd_a,
    output logic [EW-1:0]      rd_b,
    output logic [LANES-1:0]   mask,
    input  logic               wr_en,
    input  logic [LW-1:0]      wr_lane,
    input  logic [EW-1:0]      wr_data,
    input  logic               wr_err,
    output logic [LANES*EW-1:0] result,
    output logic [LANES-1:0]   err
);

    logic [LANES*EW-1:0] a_q, a_d;
    logic [LANES*EW-1:0] b_q, b_d;
    logic [LANES-1:0]    mask_q, mask_d;
    logic [LANES*EW-1:0] result_q, result_d;
    logic [LANES-1:0]    err_q, err_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        mask_d   = mask_q;
        result_d = result_q;
        err_d    = err_q;
        if (load) begin
            a_d      = load_a;
            b_d      = load_b;
            mask_d   = load_mask;
            result_d = '0;
            err_d    = '0;
        end else if (wr_en) begin
            result_d[int'(wr_lane)*EW +: EW] = wr_data;
            err_d[wr_lane]                   = wr_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // The sequencer reads one lane ahead, which can step past the last lane for non power-of-two LANES.
    assign rd_a   = (int'(rd_lane) < LANES) ? a_q[int'(rd_lane)*EW +: EW] : '0;
    assign rd_b   = (int'(rd_lane) < LANES) ? b_q[int'(rd_lane)*EW +: EW] : '0;
    assign mask   = mask_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: rtl/vdiv_seq.sv
// rtl/vdiv_seq.sv - issues a masked operand vector lane by lane to a scalar FP divider and gathers the results
module vdiv_seq
    import vdiv_pkg::*;
#(
    parameter int EXP_WIDTH  = 5,
    parameter int MANT_WIDTH = 10,
    parameter int LANES      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LANES*(EXP_WIDTH+MANT_WIDTH+1)-1:0]     in_a,
    input  logic [LANES*(EXP_WIDTH+MANT_WIDTH+1)-1:0]     in_b,
    input  logic [LANES-1:0]                              in_mask,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [LANES*(EXP_WIDTH+MANT_WIDTH+1)-1:0]     out_result,
    output logic [LANES-1:0]                              out_err,
    output logic                                          div_en,
    output logic [EXP_WIDTH+MANT_WIDTH:0]                 div_a,
    output logic [EXP_WIDTH+MANT_WIDTH:0]                 div_b,
    input  logic                                          div_done,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]                 div_result
);

    localparam int EW = EXP_WIDTH + MANT_WIDTH + 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [EW-1:0] NAN  = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    state_t         state_q, state_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_en_q, div_en_d;
    logic [EW-1:0]  div_a_q, div_a_d;
    logic [EW-1:0]  div_b_q, div_b_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic           buf_load;
    logic [LW-1:0]  lane_nxt;
    logic [EW-1:0]  buf_rd_a, buf_rd_b;
    logic [LANES-1:0] buf_mask;
    logic           wr_en;
    logic [EW-1:0]  wr_data;
    logic           wr_err;
    logic           advance;

    assign lane_nxt = lane_q + LW'(1);

    vdiv_lane_buf #(
        .EW    (EW),
        .LANES (LANES),
        .LW    (LW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_a    (in_a),
        .load_b    (in_b),
        .load_mask (in_mask),
        .rd_lane   (lane_nxt),
        .rd_a      (buf_rd_a),
        .rd_b      (buf_rd_b),
        .mask      (buf_mask),
        .wr_en     (wr_en),
        .wr_lane   (lane_q),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .result    (out_result),
        .err       (out_err)
    );

    // div_en/div_a/div_b are registered, so the request for a lane is prepared on the edge that enters ISSUE.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        div_en_d    = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        buf_load    = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_err      = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_load   = 1'b1;
                    lane_d     = '0;
                    state_d    = ISSUE;
                    in_ready_d = 1'b0;
                    if (in_mask[0]) begin
                        div_en_d = 1'b1;
                        div_a_d  = in_a[EW-1:0];
                        div_b_d  = in_b[EW-1:0];
                    end
                end
            end
            ISSUE: begin
                if (buf_mask[lane_q]) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    wr_en   = 1'b1;
                    advance = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (div_done) begin
                    wr_en   = 1'b1;
                    wr_data = div_result;
                    advance = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    wr_en   = 1'b1;
                    wr_data = NAN;
                    wr_err  = 1'b1;
                    advance = 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (lane_q == LAST) begin
                state_d     = DRAIN;
                out_valid_d = 1'b1;
            end else begin
                lane_d  = lane_nxt;
                state_d = ISSUE;
                if (buf_mask[lane_nxt]) begin
                    div_en_d = 1'b1;
                    div_a_d  = buf_rd_a;
                    div_b_d  = buf_rd_b;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            cnt_q       <= '0;
            div_en_q    <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            div_en_q    <= div_en_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign div_en    = div_en_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule

// File: tb/tb_vdiv_seq.sv
// tb/tb_vdiv_seq.sv - directed bench for vdiv_seq with a fixed-latency divider stand-in
module tb_vdiv_seq;
    import vdiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a, in_b;
    logic [3:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_err;
    logic        div_en;
    logic [15:0] div_a, div_b;
    logic        div_done;
    logic [15:0] div_result;

    int errors = 0;
    int checks = 0;

    vdiv_seq #(
        .EXP_WIDTH  (5),
        .MANT_WIDTH (10),
        .LANES      (4),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .div_en     (div_en),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    // Divider stand-in: done pulses lat cycles after the en cycle; request number drop_at never completes.
    int          lat = 3;
    int          drop_at = -1;
    int          en_count = 0;
    int          cyc_ctr = 0;
    int          en_time [0:255];
    int          en_double = 0;
    logic        en_prev = 1'b0;
    logic        m_active = 1'b0;
    int          m_left = 0;
    logic [15:0] m_res = '0;
    logic        m_done = 1'b0;

    function automatic logic [15:0] quot(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000: return 16'h3800;
            32'h4600_4200: return 16'h4000;
            32'h4000_3C00: return 16'h4000;
            32'h3800_3800: return 16'h3C00;
            32'h4400_4000: return 16'h4000;
            default:       return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc_ctr <= cyc_ctr + 1;
        en_prev <= div_en;
        m_done  <= 1'b0;
        if (div_en && en_prev) en_double <= en_double + 1;
        if (div_en) begin
            en_time[en_count] <= cyc_ctr;
            en_count <= en_count + 1;
            m_res    <= quot(div_a, div_b);
            m_active <= (en_count != drop_at);
            m_left   <= lat - 1;
        end else if (m_active) begin
            if (m_left == 1) begin
                m_done   <= 1'b1;
                m_active <= 1'b0;
            end
            m_left <= m_left - 1;
        end
    end

    assign div_done   = m_done;
    assign div_result = m_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_ready", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_mask  = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int cyc);
        cyc = 1;
        while (!out_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    localparam logic [63:0] A1 = {16'h3C00, 16'h4600, 16'h4000, 16'h3800};
    localparam logic [63:0] B1 = {16'h4000, 16'h4200, 16'h3C00, 16'h3800};
    localparam logic [63:0] Q1 = {16'h3800, 16'h4000, 16'h4000, 16'h3C00};
    localparam logic [63:0] A2 = {16'h4400, 16'h3C00, 16'h3800, 16'h4000};
    localparam logic [63:0] B2 = {16'h4000, 16'h4000, 16'h3800, 16'h3C00};
    localparam logic [63:0] Q2 = {16'h4000, 16'h3800, 16'h3C00, 16'h4000};

    initial begin
        int cyc;
        int base;
        int w;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mask   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_result", out_result,      64'd0);
        chk("rst_out_err",    64'(out_err),    64'd0);
        chk("rst_div_en",     64'(div_en),     64'd0);
        chk("rst_div_ab",     64'({div_a, div_b}), 64'd0);

        // basic all-active vector
        base = en_count;
        send(A1, B1, 4'b1111);
        wait_out(200, cyc);
        chk("basic_latency", 64'(cyc), 64'd17);
        chk("basic_result",  out_result, Q1);
        chk("basic_err",     64'(out_err), 64'd0);
        chk("basic_pulses",  64'(en_count - base), 64'd4);
        take();

        // lanes 1 and 3 masked off
        base = en_count;
        send(A1, B1, 4'b0101);
        wait_out(200, cyc);
        chk("mask_latency", 64'(cyc), 64'd11);
        chk("mask_result",  out_result, {16'h0000, 16'h4000, 16'h0000, 16'h3C00});
        chk("mask_err",     64'(out_err), 64'd0);
        chk("mask_pulses",  64'(en_count - base), 64'd2);
        take();

        // every lane masked off
        base = en_count;
        send(A1, B1, 4'b0000);
        wait_out(200, cyc);
        chk("nomask_latency", 64'(cyc), 64'd5);
        chk("nomask_result",  out_result, 64'd0);
        chk("nomask_pulses",  64'(en_count - base), 64'd0);
        take();

        // lane 2 never completes
        base = en_count;
        drop_at = base + 2;
        send(A1, B1, 4'b1111);
        wait_out(400, cyc);
        chk("tmo_latency", 64'(cyc), 64'd78);
        chk("tmo_result",  out_result, {16'h3800, CANON_NAN, 16'h4000, 16'h3C00});
        chk("tmo_err",     64'(out_err), 64'b0100);
        chk("tmo_gap",     64'(en_time[base+3] - en_time[base+2]), 64'd65);
        take();
        drop_at = -1;

        // back-pressure with a second vector waiting
        base = en_count;
        send(A1, B1, 4'b1111);
        wait_out(200, cyc);
        chk("bp_first_latency", 64'(cyc), 64'd17);
        in_a     = A2;
        in_b     = B2;
        in_mask  = 4'b1111;
        in_valid = 1'b1;
        base = en_count;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_result",    out_result,     Q1);
            @(negedge clk);
        end
        chk("bp_no_issue", 64'(en_count - base), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_hs_out_valid", 64'(out_valid), 64'd0);
        chk("bp_hs_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted",     64'(in_ready), 64'd0);
        chk("bp_first_issue",  64'({div_en, div_a, div_b}), {47'd0, 1'b1, 16'h4000, 16'h3C00});
        wait_out(200, cyc);
        chk("bp_second_latency", 64'(cyc), 64'd17);
        chk("bp_second_result",  out_result, Q2);
        take();

        // reset during lane 1's wait; its done arrives afterwards
        base = en_count;
        send(A1, B1, 4'b1111);
        w = 0;
        while (en_count < base + 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("mid_reached_lane1", 64'(en_count - base), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_in_ready",  64'(in_ready),  64'd1);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_result",    out_result,     64'd0);
        chk("mid_err",       64'(out_err),   64'd0);
        chk("mid_div",       64'({div_en, div_a, div_b}), 64'd0);
        @(negedge clk);
        chk("mid_late_done", 64'(div_done), 64'd1);
        @(negedge clk);
        chk("mid_after_done_result", out_result, 64'd0);
        chk("mid_after_done_ready",  64'(in_ready), 64'd1);
        send(A2, B2, 4'b1111);
        wait_out(200, cyc);
        chk("mid_next_latency", 64'(cyc), 64'd17);
        chk("mid_next_result",  out_result, Q2);
        chk("mid_next_err",     64'(out_err), 64'd0);
        take();

        // done lands exactly in each lane's timeout cycle
        lat = 64;
        send(A1, B1, 4'b1111);
        wait_out(600, cyc);
        chk("coin_latency", 64'(cyc), 64'd261);
        chk("coin_result",  out_result, Q1);
        chk("coin_err",     64'(out_err), 64'd0);
        take();
        lat = 3;

        chk("en_never_back_to_back", 64'(en_double), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
